// File: rtl/pipe_vr.sv
// pipe_vr: three-stage valid/ready pipeline computing f = ((a+b) +/- (c-d)) * d.
// Each stage advances independently, so empty stages fill even while downstream stalls.
module pipe_vr #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    input  logic [N-1:0]   d,
    input  logic           mode,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] f,
    output logic [1:0]     count
);

    logic           v1, v2, v3;
    logic [N-1:0]   x1, x2, d1, x3, d2;
    logic           m1;
    logic           e1, e2, e3;
    logic           v1_next, v2_next, v3_next;
    logic [N-1:0]   x3_next;
    logic [2*N-1:0] prod;
    logic [1:0]     count_next;

    always_comb begin
        e3 = !v3 || out_ready;
        e2 = !v2 || e3;
        e1 = !v1 || e2;
        // Nothing is captured on a flush or reset edge, so never advertise readiness then.
        in_ready = e1 && !flush && !rst;

        x3_next = m1 ? (x1 - x2) : (x1 + x2);
        prod    = {{N{1'b0}}, x3} * {{N{1'b0}}, d2};

        v1_next = e1 ? in_valid : v1;
        v2_next = e2 ? v1 : v2;
        v3_next = e3 ? v2 : v3;
        count_next = {1'b0, v1_next} + {1'b0, v2_next} + {1'b0, v3_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            x1    <= '0;
            x2    <= '0;
            d1    <= '0;
            m1    <= 1'b0;
            x3    <= '0;
            d2    <= '0;
            f     <= '0;
            count <= '0;
        end else if (flush) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            count <= '0;
        end else begin
            if (e1) begin
                x1 <= a + b;
                x2 <= c - d;
                d1 <= d;
                m1 <= mode;
                v1 <= in_valid;
            end
            if (e2) begin
                x3 <= x3_next;
                d2 <= d1;
                v2 <= v1;
            end
            if (e3) begin
                f  <= prod;
                v3 <= v2;
            end
            count <= count_next;
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_pipe_vr.sv
// Bench for pipe_vr: directed scenarios plus randomized traffic, checked every cycle
// against an occupancy/queue model of the pipeline.
module tb_pipe_vr;

    localparam int N = 10;
    localparam longint MASK = (longint'(1) << N) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0, b = '0, c = '0, d = '0;
    logic           mode = 1'b0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*N-1:0] f;
    logic [1:0]     count;

    pipe_vr #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .mode(mode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint calc(input longint ia, input longint ib, input longint ic,
                                    input longint id, input bit im);
        longint x1, x2, x3;
        x1 = (ia + ib) & MASK;
        x2 = (ic - id) & MASK;
        x3 = im ? ((x1 - x2) & MASK) : ((x1 + x2) & MASK);
        return x3 * id;
    endfunction

    // Model: which of the three slots hold a sample, and the in-flight results oldest first.
    bit     mv1 = 0, mv2 = 0, mv3 = 0;
    longint q[$];
    bit     f_zero = 0;
    bit     started = 0;

    always @(posedge clk) begin
        bit me1, me2, me3;
        cyc++;
        if (rst) begin
            mv1 = 0; mv2 = 0; mv3 = 0;
            q.delete();
            f_zero = 1;
            started = 1;
        end else begin
            f_zero = 0;
            if (flush) begin
                mv1 = 0; mv2 = 0; mv3 = 0;
                q.delete();
            end else begin
                me3 = !mv3 || out_ready;
                me2 = !mv2 || me3;
                me1 = !mv1 || me2;
                if (in_valid && me1) q.push_back(calc(a, b, c, d, mode));
                if (me3 && mv3) void'(q.pop_front());
                if (me3) mv3 = mv2;
                if (me2) mv2 = mv1;
                if (me1) mv1 = in_valid;
            end
        end
    end

    longint logv[$];
    int     logc[$];

    always @(negedge clk) begin
        bit xe1;
        if (started) begin
            xe1 = !mv1 || !mv2 || !mv3 || out_ready;
            if (!rst) chk("in_ready", in_ready, longint'(xe1 && !flush));
            chk("out_valid", out_valid, longint'(mv3));
            chk("count", count, longint'(mv1) + longint'(mv2) + longint'(mv3));
            if (mv3) begin
                if (q.size() > 0) chk("f", f, q[0]);
                else chk("model_queue_nonempty", 0, 1);
            end
            if (f_zero) chk("f_after_reset", f, 0);
            if (!rst && out_valid && out_ready) begin
                logv.push_back(f);
                logc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int ia, input int ib, input int ic,
                          input int id, input bit im);
        in_valid = v;
        a = ia[N-1:0]; b = ib[N-1:0]; c = ic[N-1:0]; d = id[N-1:0];
        mode = im;
    endtask

    task automatic send(input int ia, input int ib, input int ic, input int id, input bit im);
        set_in(1'b1, ia, ib, ic, id, im);
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    int k0;
    logic [2*N-1:0] f_hold;

    initial begin
        // Model pins against hand-computed values.
        chk("pin_52", calc(10, 12, 6, 2, 0), 52);
        chk("pin_112", calc(20, 11, 1, 4, 0), 112);
        chk("pin_36", calc(10, 12, 6, 2, 1), 36);
        chk("pin_512000", calc(1000, 0, 512, 512, 0), 512000);

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_count", count, 0);

        // Streaming
        logv.delete(); logc.delete();
        out_ready = 1'b1;
        send(10, 12, 6, 2, 0); k0 = cyc; chk("ramp1", count, 1);
        send(10, 10, 5, 3, 0); chk("ramp2", count, 2);
        send(20, 11, 1, 4, 0); chk("ramp3", count, 3);
        send(12, 15, 4, 2, 0); chk("ramp4", count, 3);
        idle(6);
        chk("stream_n", logv.size(), 4);
        if (logv.size() == 4) begin
            chk("stream_f0", logv[0], 52);
            chk("stream_f1", logv[1], 66);
            chk("stream_f2", logv[2], 112);
            chk("stream_f3", logv[3], 58);
            chk("stream_latency", logc[0], k0 + 2);
            for (int i = 1; i < 4; i++) chk("stream_consecutive", logc[i], logc[0] + i);
        end

        // Mode and wrap
        logv.delete(); logc.delete();
        send(10, 12, 6, 2, 1);
        send(1023, 1, 0, 1, 0);
        send(1000, 0, 512, 512, 0);
        idle(6);
        chk("wrap_n", logv.size(), 3);
        if (logv.size() == 3) begin
            chk("mode1_f", logv[0], 36);
            chk("wrap_f", logv[1], 1023);
            chk("wide_f", logv[2], 512000);
        end

        // Backpressure
        logv.delete(); logc.delete();
        out_ready = 1'b0;
        send(5, 6, 7, 1, 0);
        send(100, 200, 300, 50, 1);
        send(7, 7, 7, 7, 0);
        chk("bp_full", count, 3);
        f_hold = f;
        set_in(1'b1, 3, 3, 3, 3, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_count", count, 3);
            chk("bp_f_stable", f, f_hold);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("bp_release_ready", in_ready, 1);
        idle(6);
        chk("bp_n", logv.size(), 3);
        if (logv.size() == 3) begin
            chk("bp_f0", logv[0], calc(5, 6, 7, 1, 0));
            chk("bp_f1", logv[1], calc(100, 200, 300, 50, 1));
            chk("bp_f2", logv[2], calc(7, 7, 7, 7, 0));
        end

        // Bubble collapse
        logv.delete(); logc.delete();
        out_ready = 1'b0;
        send(1, 2, 3, 4, 0);
        idle(2);
        chk("bub_count1", count, 1);
        chk("bub_v3", out_valid, 1);
        set_in(1'b1, 30, 40, 9, 5, 1);
        #1; chk("bub_ready_a", in_ready, 1);
        step();
        set_in(1'b1, 8, 9, 10, 11, 0);
        #1; chk("bub_ready_b", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bub_count3", count, 3);
        chk("bub_ready_full", in_ready, 0);
        out_ready = 1'b1;
        idle(6);
        chk("bub_n", logv.size(), 3);
        if (logv.size() == 3) begin
            chk("bub_f0", logv[0], calc(1, 2, 3, 4, 0));
            chk("bub_f1", logv[1], calc(30, 40, 9, 5, 1));
            chk("bub_f2", logv[2], calc(8, 9, 10, 11, 0));
        end

        // Flush mid-stream
        out_ready = 1'b0;
        send(11, 22, 33, 4, 0);
        send(12, 23, 34, 5, 1);
        send(13, 24, 35, 6, 0);
        set_in(1'b1, 99, 99, 99, 9, 0);
        flush = 1'b1;
        #1; chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        logv.delete(); logc.delete();
        out_ready = 1'b1;
        idle(6);
        chk("flush_no_output", logv.size(), 0);

        // Reset mid-stream
        out_ready = 1'b0;
        send(11, 22, 33, 4, 0);
        send(12, 23, 34, 5, 1);
        send(13, 24, 35, 6, 0);
        set_in(1'b1, 99, 99, 99, 9, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f", f, 0);
        logv.delete(); logc.delete();
        out_ready = 1'b1;
        send(10, 12, 6, 2, 0); k0 = cyc;
        idle(6);
        chk("post_rst_n", logv.size(), 1);
        if (logv.size() == 1) begin
            chk("post_rst_f", logv[0], 52);
            chk("post_rst_latency", logc[0], k0 + 2);
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a = N'($urandom); b = N'($urandom); c = N'($urandom); d = N'($urandom);
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
